// File: rtl/calc_ctrl_if.sv
// Keypad handshake, ALU operand/control and display signals of the calculator front end.
// master: the calc_ctrl sequencer; slave: keypad decoder, ALU and display side.
interface calc_ctrl_if #(
    parameter int ALU_W  = 16,
    parameter int CALC_W = 11
);
    logic              KEY_VALID;
    logic [4:0]        KEY_CODE;
    logic              KEY_READY;
    logic              KEY_REJ;
    logic [ALU_W-1:0]  ALU_A;
    logic [ALU_W-1:0]  ALU_B;
    logic [2:0]        ALU_CTRL;
    logic [ALU_W-1:0]  ALU_RESULT;
    logic [CALC_W-1:0] DISP;
    logic              DONE;
    logic              ERROR;

    modport master (
        input  KEY_VALID, KEY_CODE, ALU_RESULT,
        output KEY_READY, KEY_REJ, ALU_A, ALU_B, ALU_CTRL, DISP, DONE, ERROR
    );

    modport slave (
        output KEY_VALID, KEY_CODE, ALU_RESULT,
        input  KEY_READY, KEY_REJ, ALU_A, ALU_B, ALU_CTRL, DISP, DONE, ERROR
    );
endinterface

// File: rtl/calc_ctrl.sv
// Calculator front-end sequencer: keypad operand entry, one ALU operation, range-checked result.
// Define CALC_CHAIN_EN to let an operator key after a result reuse that result as operand A.
module calc_ctrl #(
    parameter int ALU_W      = 16,
    parameter int CALC_W     = 11,
    parameter int MAX_DIGITS = 4
) (
    input logic         CLK,
    input logic         RESET_N,
    calc_ctrl_if.master bus
);
    localparam int MAG_W   = CALC_W - 1;
    localparam int MAG_MAX = (1 << MAG_W) - 1;
    localparam int GROW_W  = MAG_W + 4;
    localparam int CNT_W   = $clog2(MAX_DIGITS + 1);

    localparam logic [4:0] KEY_ADD = 5'd10;
    localparam logic [4:0] KEY_SUB = 5'd11;
    localparam logic [4:0] KEY_AND = 5'd12;
    localparam logic [4:0] KEY_OR  = 5'd13;
    localparam logic [4:0] KEY_EQ  = 5'd14;
    localparam logic [4:0] KEY_CLR = 5'd15;
    localparam logic [4:0] KEY_NEG = 5'd16;

    localparam logic [2:0] OP_PASS = 3'b100;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        CAPTURE,
        SHOW,
        ERR
    } state_t;

    state_t              state, state_n;
    logic [MAG_W-1:0]    mag, mag_n;
    logic                neg, neg_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [CALC_W-1:0]   a_val, a_n;
    logic [CALC_W-1:0]   b_val, b_n;
    logic [2:0]          opcode, opcode_n;
    logic [CALC_W-1:0]   result, result_n;
    logic                error, error_n;
    logic                done, done_n;
    logic                rej, rej_n;

    logic                busy;
    logic                accept;
    logic                is_digit;
    logic                is_op;
    logic                clr;
    logic [2:0]          key_op;
    logic [GROW_W-1:0]   grown;
    logic [CALC_W-1:0]   mag_ext;
    logic [CALC_W-1:0]   operand;
    logic [ALU_W-CALC_W:0] res_hi;
    logic                ovf;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state  <= ENTER_A;
            mag    <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            a_val  <= '0;
            b_val  <= '0;
            opcode <= '0;
            result <= '0;
            error  <= 1'b0;
            done   <= 1'b0;
            rej    <= 1'b0;
        end else begin
            state  <= state_n;
            mag    <= mag_n;
            neg    <= neg_n;
            cnt    <= cnt_n;
            a_val  <= a_n;
            b_val  <= b_n;
            opcode <= opcode_n;
            result <= result_n;
            error  <= error_n;
            done   <= done_n;
            rej    <= rej_n;
        end
    end

    assign busy     = (state == EXEC) || (state == CAPTURE);
    assign accept   = bus.KEY_VALID && !busy;
    assign is_digit = bus.KEY_CODE <= 5'd9;
    assign is_op    = (bus.KEY_CODE >= KEY_ADD) && (bus.KEY_CODE <= KEY_OR);
    assign grown    = GROW_W'(mag) * GROW_W'(10) + GROW_W'(bus.KEY_CODE[3:0]);
    assign mag_ext  = {1'b0, mag};
    // Negative zero negates to zero, so it needs no special case on the display.
    assign operand  = neg ? (~mag_ext + CALC_W'(1)) : mag_ext;
    assign res_hi   = bus.ALU_RESULT[ALU_W-1:CALC_W-1];
    assign ovf      = !((&res_hi) || (~|res_hi));

    always_comb begin
        case (bus.KEY_CODE)
            KEY_ADD: key_op = 3'b000;
            KEY_SUB: key_op = 3'b001;
            KEY_AND: key_op = 3'b010;
            default: key_op = 3'b011;
        endcase
    end

    always_comb begin
        state_n  = state;
        mag_n    = mag;
        neg_n    = neg;
        cnt_n    = cnt;
        a_n      = a_val;
        b_n      = b_val;
        opcode_n = opcode;
        result_n = result;
        error_n  = error;
        done_n   = 1'b0;
        rej_n    = 1'b0;
        clr      = 1'b0;

        case (state)
            ENTER_A, ENTER_B: begin
                if (accept) begin
                    if (is_digit) begin
                        if (cnt < CNT_W'(MAX_DIGITS) && grown <= GROW_W'(MAG_MAX)) begin
                            mag_n = grown[MAG_W-1:0];
                            cnt_n = cnt + CNT_W'(1);
                        end else begin
                            rej_n = 1'b1;
                        end
                    end else if (is_op) begin
                        opcode_n = key_op;
                        if (state == ENTER_A) begin
                            a_n     = operand;
                            mag_n   = '0;
                            neg_n   = 1'b0;
                            cnt_n   = '0;
                            state_n = ENTER_B;
                        end
                    end else begin
                        case (bus.KEY_CODE)
                            KEY_NEG: neg_n = ~neg;
                            KEY_EQ: begin
                                if (state == ENTER_A) begin
                                    a_n      = operand;
                                    b_n      = '0;
                                    opcode_n = OP_PASS;
                                end else begin
                                    b_n = operand;
                                end
                                state_n = EXEC;
                            end
                            KEY_CLR: clr   = 1'b1;
                            default: rej_n = 1'b1;
                        endcase
                    end
                end
            end
            EXEC: state_n = CAPTURE;
            CAPTURE: begin
                if (ovf) begin
                    error_n  = 1'b1;
                    result_n = '0;
                    state_n  = ERR;
                end else begin
                    result_n = bus.ALU_RESULT[CALC_W-1:0];
                    done_n   = 1'b1;
                    state_n  = SHOW;
                end
            end
            SHOW: begin
                if (accept) begin
                    if (is_digit) begin
                        mag_n   = MAG_W'(bus.KEY_CODE[3:0]);
                        neg_n   = 1'b0;
                        cnt_n   = CNT_W'(1);
                        state_n = ENTER_A;
                    end else if (bus.KEY_CODE == KEY_NEG) begin
                        mag_n   = '0;
                        neg_n   = 1'b1;
                        cnt_n   = '0;
                        state_n = ENTER_A;
                    end else if (is_op) begin
`ifdef CALC_CHAIN_EN
                        a_n      = result;
                        opcode_n = key_op;
                        mag_n    = '0;
                        neg_n    = 1'b0;
                        cnt_n    = '0;
                        state_n  = ENTER_B;
`else
                        rej_n = 1'b1;
`endif
                    end else if (bus.KEY_CODE == KEY_CLR) begin
                        clr = 1'b1;
                    end else begin
                        rej_n = 1'b1;
                    end
                end
            end
            ERR: begin
                if (accept) begin
                    if (bus.KEY_CODE == KEY_CLR) clr = 1'b1;
                    else                         rej_n = 1'b1;
                end
            end
            default: state_n = ENTER_A;
        endcase

        if (clr) begin
            state_n  = ENTER_A;
            mag_n    = '0;
            neg_n    = 1'b0;
            cnt_n    = '0;
            a_n      = '0;
            b_n      = '0;
            opcode_n = '0;
            result_n = '0;
            error_n  = 1'b0;
        end
    end

    always_comb begin
        bus.KEY_READY = !busy;
        bus.KEY_REJ   = rej;
        bus.DONE      = done;
        bus.ERROR     = error;
        bus.ALU_CTRL  = busy ? opcode : OP_PASS;
        bus.ALU_A     = {{(ALU_W-CALC_W){a_val[CALC_W-1]}}, a_val};
        bus.ALU_B     = {{(ALU_W-CALC_W){b_val[CALC_W-1]}}, b_val};
        case (state)
            SHOW:    bus.DISP = result;
            ERR:     bus.DISP = '0;
            default: bus.DISP = operand;
        endcase
    end
endmodule

// File: tb/tb_calc_ctrl.sv
// Directed-key bench for calc_ctrl with an integer-level calculator model and a bench-side ALU.
module tb_calc_ctrl;
    localparam int ALU_W      = 16;
    localparam int CALC_W     = 11;
    localparam int MAX_DIGITS = 4;
`ifdef CALC_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    localparam int M_A = 0, M_B = 1, M_X1 = 2, M_X2 = 3, M_SHOW = 4, M_ERR = 5;

    logic CLK = 1'b0;
    logic RESET_N;
    always #5 CLK = ~CLK;

    calc_ctrl_if #(.ALU_W(ALU_W), .CALC_W(CALC_W)) bus ();

    calc_ctrl #(.ALU_W(ALU_W), .CALC_W(CALC_W), .MAX_DIGITS(MAX_DIGITS)) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    always_comb begin
        case (bus.ALU_CTRL)
            3'b000:  bus.ALU_RESULT = bus.ALU_A + bus.ALU_B;
            3'b001:  bus.ALU_RESULT = bus.ALU_A - bus.ALU_B;
            3'b010:  bus.ALU_RESULT = bus.ALU_A & bus.ALU_B;
            3'b011:  bus.ALU_RESULT = bus.ALU_A | bus.ALU_B;
            default: bus.ALU_RESULT = bus.ALU_A;
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Calculator model: operands as signed integers, outcome decided when equals is taken.
    int m_mode, m_mag, m_cnt, m_a, m_b, m_op, m_res, m_pend;
    bit m_neg, m_err, m_ovf, e_rej, e_done;

    function automatic int m_operand();
        return m_neg ? -m_mag : m_mag;
    endfunction

    task automatic m_clear_entry();
        m_mag = 0;
        m_neg = 1'b0;
        m_cnt = 0;
    endtask

    task automatic m_reset();
        m_clear_entry();
        m_mode = M_A;
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_pend = 0;
        m_err = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic m_start();
        int r;
        case (m_op)
            0:       r = m_a + m_b;
            1:       r = m_a - m_b;
            2:       r = m_a & m_b;
            3:       r = m_a | m_b;
            default: r = m_a;
        endcase
        m_pend = r;
        m_ovf  = (r < -1024) || (r > 1023);
        m_mode = M_X1;
    endtask

    task automatic m_key(input int k);
        int nv;
        if (k == 15) begin
            m_reset();
        end else if (m_mode == M_A || m_mode == M_B) begin
            if (k <= 9) begin
                nv = m_mag * 10 + k;
                if (m_cnt + 1 <= MAX_DIGITS && nv <= 1023) begin
                    m_mag = nv;
                    m_cnt++;
                end else e_rej = 1'b1;
            end else if (k >= 10 && k <= 13) begin
                m_op = k - 10;
                if (m_mode == M_A) begin
                    m_a = m_operand();
                    m_clear_entry();
                    m_mode = M_B;
                end
            end else if (k == 16) begin
                m_neg = !m_neg;
            end else if (k == 14) begin
                if (m_mode == M_A) begin
                    m_a = m_operand();
                    m_b = 0;
                    m_op = 4;
                end else m_b = m_operand();
                m_start();
            end else e_rej = 1'b1;
        end else if (m_mode == M_SHOW) begin
            if (k <= 9) begin
                m_mag = k; m_neg = 1'b0; m_cnt = 1; m_mode = M_A;
            end else if (k == 16) begin
                m_mag = 0; m_neg = 1'b1; m_cnt = 0; m_mode = M_A;
            end else if (k >= 10 && k <= 13 && CHAIN) begin
                m_a = m_res; m_op = k - 10; m_clear_entry(); m_mode = M_B;
            end else e_rej = 1'b1;
        end else begin
            e_rej = 1'b1;
        end
    endtask

    always @(posedge CLK) begin
        e_rej  = 1'b0;
        e_done = 1'b0;
        if (!RESET_N) m_reset();
        else if (m_mode == M_X1) m_mode = M_X2;
        else if (m_mode == M_X2) begin
            if (m_ovf) begin
                m_mode = M_ERR; m_err = 1'b1; m_res = 0;
            end else begin
                m_res = m_pend; e_done = 1'b1; m_mode = M_SHOW;
            end
        end else if (bus.KEY_VALID) m_key(int'(bus.KEY_CODE));
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            bit busy;
            int disp;
            busy = (m_mode == M_X1) || (m_mode == M_X2);
            if (m_mode == M_SHOW)     disp = m_res & 'h7FF;
            else if (m_mode == M_ERR) disp = 0;
            else                      disp = m_operand() & 'h7FF;
            chk("m_key_ready", bus.KEY_READY, busy ? 0 : 1);
            chk("m_key_rej", bus.KEY_REJ, e_rej);
            chk("m_done", bus.DONE, e_done);
            chk("m_error", bus.ERROR, m_err);
            chk("m_disp", bus.DISP, disp);
            chk("m_alu_ctrl", bus.ALU_CTRL, busy ? m_op : 4);
            if (busy) begin
                chk("m_alu_a", bus.ALU_A, m_a & 'hFFFF);
                chk("m_alu_b", bus.ALU_B, m_b & 'hFFFF);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic press(input int k);
        bus.KEY_VALID = 1'b1;
        bus.KEY_CODE  = 5'(k);
        step();
        bus.KEY_VALID = 1'b0;
        bus.KEY_CODE  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0;
        bus.KEY_VALID = 1'b0;
        bus.KEY_CODE  = '0;
        step();
        chk_en = 1'b1;
        chk("rst_ready", bus.KEY_READY, 1);
        chk("rst_ctrl", bus.ALU_CTRL, 4);
        chk("rst_disp", bus.DISP, 0);
        chk("rst_alu_a", bus.ALU_A, 0);
        chk("rst_error", bus.ERROR, 0);
        RESET_N = 1'b1;

        // 12 + 34 = 46
        press(1); press(2); press(10); press(3); press(4); press(14);
        chk("add_ctrl_exec", bus.ALU_CTRL, 0);
        chk("add_a", bus.ALU_A, 12);
        chk("add_b", bus.ALU_B, 34);
        chk("add_ready_exec", bus.KEY_READY, 0);
        step();
        chk("add_done_early", bus.DONE, 0);
        step();
        chk("add_done", bus.DONE, 1);
        chk("add_disp", bus.DISP, 46);
        chk("add_error", bus.ERROR, 0);
        step();
        chk("add_done_pulse", bus.DONE, 0);

        // 5 - 9 = -4, then new A: 8 negated
        press(5); press(11); press(9); press(14);
        chk("sub_ctrl", bus.ALU_CTRL, 1);
        step(); step();
        chk("sub_disp", bus.DISP, 11'h7FC);
        press(8); press(16);
        chk("neg_disp", bus.DISP, 11'h7F8);

        // digit entry limits
        press(15); press(1); press(0); press(2); press(4);
        chk("lim_rej", bus.KEY_REJ, 1);
        chk("lim_disp", bus.DISP, 102);
        step();
        chk("lim_rej_pulse", bus.KEY_REJ, 0);
        press(7);
        chk("lim_rej2", bus.KEY_REJ, 1);
        chk("lim_disp2", bus.DISP, 102);

        // 1000 + 100 overflows
        press(15);
        press(1); press(0); press(0); press(0); press(10); press(1); press(0); press(0); press(14);
        step(); step();
        chk("ovf_error", bus.ERROR, 1);
        chk("ovf_disp", bus.DISP, 0);
        chk("ovf_done", bus.DONE, 0);
        press(3);
        chk("err_rej", bus.KEY_REJ, 1);
        chk("err_hold", bus.ERROR, 1);
        press(15);
        chk("clr_error", bus.ERROR, 0);
        chk("clr_disp", bus.DISP, 0);

        // 12 & 10 = 8, then or/chain
        press(1); press(2); press(12); press(1); press(0); press(14);
        chk("and_ctrl", bus.ALU_CTRL, 2);
        step(); step();
        chk("and_disp", bus.DISP, 8);
        press(13);
        chk("or_rej", bus.KEY_REJ, CHAIN ? 0 : 1);
        press(3); press(14);
        step(); step();
        chk("or_disp", bus.DISP, CHAIN ? 11 : 3);
        press(14);
        chk("show_eq_rej", bus.KEY_REJ, 1);
        chk("show_eq_disp", bus.DISP, CHAIN ? 11 : 3);
        press(20);
        chk("reserved_rej", bus.KEY_REJ, 1);

        // reset during EXEC
        press(15); press(5); press(14);
        chk("mid_ready", bus.KEY_READY, 0);
        RESET_N = 1'b0;
        step();
        chk("mid_done", bus.DONE, 0);
        chk("mid_ready_rst", bus.KEY_READY, 1);
        chk("mid_ctrl", bus.ALU_CTRL, 4);
        chk("mid_disp", bus.DISP, 0);
        RESET_N = 1'b1;
        step();
        chk("mid_no_done", bus.DONE, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
